brouter_nic: RTL and testbench

Network interface that sits directly on the local port (port 4) of the bufferless `brouter`. It buffers core-side injection flits and presents them to the router only when the router signals a free injection slot. It also captures every flit the router ejects on port 4 and queues it for the core behind a valid/ready handshake. Because the router cannot back-pressure ejection, ejection overflow is counted and flagged rather than stalled.

---
 rtl/brouter_nic.sv | 149 ++++++++++++++
 tb/tb_brouter_nic.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/brouter_nic.sv
// Local-port NIC for the bufferless brouter: an injection queue toward the router and an ejection queue toward the core.
// Latency: 1 cycle from core push to rtr_ci, 1 cycle from rtr_co to ej_valid.
// Backpressure: inj_ready drops when the injection queue is full; ejection cannot stall, so overflow flits are dropped and counted.
//
// Ports:
//   clk, rst (async active-low)
//   inj_valid/inj_ready/inj_ctrl/inj_data  core -> NIC flits
//   rtr_ci/rtr_di/rtr_ready                NIC -> router port 4 injection
//   rtr_co/rtr_do                          router port 4 ejection -> NIC
//   ej_valid/ej_ready/ej_ctrl/ej_data      NIC -> core flits
//   inj_count/ej_count                     queue occupancies
//   ej_drop/drop_cnt                       sticky loss flag and saturating loss counter

// Generic queue used for both directions.
// Latency: a push at edge N is visible at the head after edge N.
// Backpressure: a push is taken when not full, or when full and a pop happens at the same edge.
module brouter_nic_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop   = pop && (count != '0);
  assign do_push  = push && ((count != FULL) || do_pop);
  // Head reads as zero when empty so downstream sees an idle (invalid) flit.
  assign head_dat = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observable while count covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module brouter_nic #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inj_valid,
  output logic                     inj_ready,
  input  logic [CTRL_W-1:0]        inj_ctrl,
  input  logic [DATA_W-1:0]        inj_data,
  output logic [CTRL_W-1:0]        rtr_ci,
  output logic [DATA_W-1:0]        rtr_di,
  input  logic                     rtr_ready,
  input  logic [CTRL_W-1:0]        rtr_co,
  input  logic [DATA_W-1:0]        rtr_do,
  output logic                     ej_valid,
  input  logic                     ej_ready,
  output logic [CTRL_W-1:0]        ej_ctrl,
  output logic [DATA_W-1:0]        ej_data,
  output logic [$clog2(DEPTH):0]   inj_count,
  output logic [$clog2(DEPTH):0]   ej_count,
  output logic                     ej_drop,
  output logic [7:0]               drop_cnt
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CTRL_W-1:0]        inj_ctrl_v;
  logic                     inj_push;
  logic                     ej_push;
  logic                     drop;
  logic [CTRL_W+DATA_W-1:0] inj_head;
  logic [CTRL_W+DATA_W-1:0] ej_head;

  // Whatever the core supplies, a queued injection flit is always marked valid.
  always_comb begin
    inj_ctrl_v             = inj_ctrl;
    inj_ctrl_v[CTRL_W-1]   = 1'b1;
  end

  assign inj_ready = (inj_count < FULL);
  assign inj_push  = inj_valid && inj_ready;

  brouter_nic_fifo #(.W(CTRL_W + DATA_W), .DEPTH(DEPTH)) u_inj_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inj_push),
    .push_dat ({inj_ctrl_v, inj_data}),
    .pop      (rtr_ready),
    .head_dat (inj_head),
    .count    (inj_count)
  );

  assign {rtr_ci, rtr_di} = inj_head;

  // Ejection is driven purely by the router's valid bit; there is no way to stall it.
  assign ej_push = rtr_co[CTRL_W-1];
  // Full and not popping this edge: the incoming flit has nowhere to go.
  assign drop    = ej_push && (ej_count == FULL) && !ej_ready;

  brouter_nic_fifo #(.W(CTRL_W + DATA_W), .DEPTH(DEPTH)) u_ej_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (ej_push),
    .push_dat ({rtr_co, rtr_do}),
    .pop      (ej_ready),
    .head_dat (ej_head),
    .count    (ej_count)
  );

  assign ej_valid         = (ej_count != '0);
  assign {ej_ctrl, ej_data} = ej_head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ej_drop  <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (drop) begin
      ej_drop <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_brouter_nic.sv
module tb_brouter_nic;
  localparam int CTRL_W = 16;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;
  localparam int FW     = CTRL_W + DATA_W;
  localparam int SB     = 1024;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              inj_valid = 1'b0;
  logic              inj_ready;
  logic [CTRL_W-1:0] inj_ctrl = '0;
  logic [DATA_W-1:0] inj_data = '0;
  logic [CTRL_W-1:0] rtr_ci;
  logic [DATA_W-1:0] rtr_di;
  logic              rtr_ready = 1'b0;
  logic [CTRL_W-1:0] rtr_co = '0;
  logic [DATA_W-1:0] rtr_do = '0;
  logic              ej_valid;
  logic              ej_ready = 1'b0;
  logic [CTRL_W-1:0] ej_ctrl;
  logic [DATA_W-1:0] ej_data;
  logic [2:0]        inj_count;
  logic [2:0]        ej_count;
  logic              ej_drop;
  logic [7:0]        drop_cnt;

  brouter_nic #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .inj_valid (inj_valid),
    .inj_ready (inj_ready),
    .inj_ctrl  (inj_ctrl),
    .inj_data  (inj_data),
    .rtr_ci    (rtr_ci),
    .rtr_di    (rtr_di),
    .rtr_ready (rtr_ready),
    .rtr_co    (rtr_co),
    .rtr_do    (rtr_do),
    .ej_valid  (ej_valid),
    .ej_ready  (ej_ready),
    .ej_ctrl   (ej_ctrl),
    .ej_data   (ej_data),
    .inj_count (inj_count),
    .ej_count  (ej_count),
    .ej_drop   (ej_drop),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state (written only by the model process).
  logic [FW-1:0] exp_inj [SB];
  logic [FW-1:0] exp_ej  [SB];
  int wi = 0;
  int we = 0;
  int inj_occ = 0;
  int ej_occ = 0;
  int m_drop_cnt = 0;
  bit m_drop = 1'b0;

  // Scoreboard read side (written only by the monitor).
  int ri = 0;
  int re = 0;
  int checks = 0;
  int passed = 0;

  // Behavioural model: queues of expected flits plus occupancy arithmetic, updated at each edge.
  always @(posedge clk) begin
    bit ipop, ipush, epop;
    logic [CTRL_W-1:0] c;
    if (!rst) begin
      inj_occ    = 0;
      ej_occ     = 0;
      m_drop     = 1'b0;
      m_drop_cnt = 0;
    end else begin
      ipop  = (inj_occ > 0) && rtr_ready;
      ipush = inj_valid && (inj_occ < DEPTH);
      if (ipush) begin
        c = inj_ctrl;
        c[CTRL_W-1] = 1'b1;
        exp_inj[wi % SB] = {c, inj_data};
        wi++;
      end
      inj_occ = inj_occ + int'(ipush) - int'(ipop);

      epop = (ej_occ > 0) && ej_ready;
      if (rtr_co[CTRL_W-1]) begin
        if (ej_occ < DEPTH || epop) begin
          exp_ej[we % SB] = {rtr_co, rtr_do};
          we++;
          ej_occ++;
        end else begin
          m_drop = 1'b1;
          if (m_drop_cnt < 255) m_drop_cnt++;
        end
      end
      if (epop) ej_occ--;
    end
  end

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: samples on the falling edge; pops the scoreboard when a transfer will occur at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_rtr_ci",    FW'(rtr_ci),    '0);
      chk("rst_rtr_di",    FW'(rtr_di),    '0);
      chk("rst_ej_valid",  FW'(ej_valid),  '0);
      chk("rst_ej_ctrl",   FW'(ej_ctrl),   '0);
      chk("rst_ej_data",   FW'(ej_data),   '0);
      chk("rst_inj_count", FW'(inj_count), '0);
      chk("rst_ej_count",  FW'(ej_count),  '0);
      chk("rst_ej_drop",   FW'(ej_drop),   '0);
      chk("rst_drop_cnt",  FW'(drop_cnt),  '0);
      chk("rst_inj_ready", FW'(inj_ready), FW'(1));
      ri = wi;
      re = we;
    end else begin
      chk("inj_count", FW'(inj_count), FW'(inj_occ));
      chk("inj_ready", FW'(inj_ready), FW'(inj_occ < DEPTH));
      chk("ej_count",  FW'(ej_count),  FW'(ej_occ));
      chk("ej_valid",  FW'(ej_valid),  FW'(ej_occ != 0));
      chk("ej_drop",   FW'(ej_drop),   FW'(m_drop));
      chk("drop_cnt",  FW'(drop_cnt),  FW'(m_drop_cnt));
      if (ri != wi) begin
        chk("rtr_head", {rtr_ci, rtr_di}, exp_inj[ri % SB]);
        if (rtr_ready) ri++;
      end else begin
        chk("rtr_idle", {rtr_ci, rtr_di}, '0);
      end
      if (re != we) begin
        chk("ej_head", {ej_ctrl, ej_data}, exp_ej[re % SB]);
        if (ej_ready) re++;
      end else begin
        chk("ej_idle", {ej_ctrl, ej_data}, '0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    inj_valid = 1'b0;
    inj_ctrl  = '0;
    inj_data  = '0;
    rtr_ready = 1'b0;
    rtr_co    = '0;
    rtr_do    = '0;
    ej_ready  = 1'b0;
  endtask

  task automatic drive_random(input int c);
    inj_valid = 1'($urandom_range(0, 1));
    inj_ctrl  = CTRL_W'($urandom);
    inj_data  = {$urandom, $urandom};
    rtr_ready = ($urandom_range(0, 3) != 0);
    rtr_co    = CTRL_W'($urandom);
    rtr_do    = {$urandom, $urandom};
    // Alternate segments of mostly-stalled and mostly-draining core to reach full and empty often.
    ej_ready  = ((c / 300) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    // Reset held with random inputs: nothing may be captured.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_random(i);
      tick();
    end
    drive_idle();
    rst = 1'b1;
    repeat (3) tick();

    // Single injection with the router ready.
    inj_valid = 1'b1;
    inj_ctrl  = 16'h0005;
    inj_data  = 64'h1122334455667788;
    rtr_ready = 1'b1;
    tick();
    inj_valid = 1'b0;
    repeat (4) tick();

    // Injection backpressure: four fill the queue, the fifth waits for space.
    rtr_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      inj_valid = 1'b1;
      inj_ctrl  = CTRL_W'(i);
      inj_data  = DATA_W'(i);
      tick();
    end
    repeat (2) tick();
    rtr_ready = 1'b1;
    tick();
    tick();
    inj_valid = 1'b0;
    repeat (6) tick();
    rtr_ready = 1'b0;

    // Single ejection held until the core accepts it.
    rtr_co = 16'h8003;
    rtr_do = 64'hA;
    tick();
    rtr_co = '0;
    rtr_do = '0;
    repeat (2) tick();
    ej_ready = 1'b1;
    repeat (2) tick();

    // Ejection overflow: six back-to-back flits into a stalled core.
    ej_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      rtr_co = 16'h8000 | CTRL_W'(i);
      rtr_do = DATA_W'(i);
      tick();
    end
    rtr_co = 16'h0001;
    tick();

    // Full queue with a simultaneous core pop: no drop.
    ej_ready = 1'b1;
    rtr_co   = 16'h8007;
    rtr_do   = 64'h7;
    tick();
    ej_ready = 1'b0;
    rtr_co   = '0;
    tick();

    // Saturate the drop counter.
    for (int i = 0; i < 300; i++) begin
      rtr_co = 16'h8000 | CTRL_W'($urandom);
      rtr_do = {$urandom, $urandom};
      tick();
    end
    rtr_co   = '0;
    ej_ready = 1'b1;
    repeat (6) tick();

    // Reset to clear the sticky drop state before randomized traffic.
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();

    for (int c = 0; c < 3000; c++) begin
      drive_random(c);
      if (c == 1500) rst = 1'b0;
      if (c == 1502) rst = 1'b1;
      tick();
    end

    drive_idle();
    rtr_ready = 1'b1;
    ej_ready  = 1'b1;
    repeat (8) tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
